spi_master_gen2: RTL and testbench
==================================

# spi_master_gen2

Parametrised SPI master that serialises a transmit word on MOSI and captures MISO into a receive register, with programmable frame length, SCK divider, all four CPOL/CPHA modes, bit order and multiple slave selects. It sits between the boot-control logic and external SPI devices (flash, ADC, peripheral MCU). It is the generalised successor of the fixed 48-bit-TX / 80-bit-RX master. It adds explicit busy/done handshaking and abort.

## Interface
- TX_W, 48, transmit register width (≥1)
- RX_W, 80, receive register width (≥1)
- NUM_CS, 1, number of active-low slave selects (≥1)
- DIV_W, 8, width of clock divider input
- spi_clk_i  in  1  system clock. Single clock domain; all logic on its rising edge.
- spi_rst_i  in  1  asynchronous, active-low reset
- spi_start_i  in  1  start request; sampled only in IDLE
- spi_abort_i  in  1  abort current frame
- spi_fbo_i  in  1  1 = MSB first, 0 = LSB first
- spi_cpol_i  in  1  SCK idle level
- spi_cpha_i  in  1  0 = sample on leading edge, 1 = sample on trailing edge
- clock_divider_i  in  DIV_W  half SCK period = clock_divider_i+1 system clocks (D)
- frame_len_i  in  8  number of bits in frame (1..255)
- cs_mask_i  in  NUM_CS  one-hot/multi-hot select; bit set → that SS line asserted
- transmission_data_i  in  TX_W  data to send
- MISO  in  1  serial input
- SCK  out  1  serial clock
- MOSI  out  1  serial output
- SS  out  NUM_CS  active-low selects
- busy  out  1  high from accepted start to done/abort
- done  out  1  one-cycle completion pulse
- received_data_o  out  RX_W  captured frame, valid from done

## Operation
- Reset values: SCK=0, MOSI=1, SS=all 1s, busy=0, done=0, received_data_o=all 1s, state IDLE.
- States: IDLE → LEAD → XFER → TRAIL → IDLE.
- IDLE: SCK=spi_cpol_i (live), MOSI=1, SS high.
  - spi_start_i=1 with frame_len_i≠0 latches fbo, cpol, cpha, D, len, cs_mask and transmission_data_i. It also clears the RX shift register to all 1s and moves to LEAD.
  - start with frame_len_i=0 is ignored.
- LEAD: busy=1. SS[i]=~cs_mask[i]. SCK held at latched cpol. MOSI = first TX bit. Lasts D cycles.
- XFER: SCK toggles every D cycles, 2·len edges total.
  - CPHA=0: sample MISO on odd edges (1,3,…); advance MOSI on even edges except the last.
  - CPHA=1: advance MOSI on odd edges (first bit driven on edge 1, not in LEAD); sample on even edges.
  - MISO is sampled into the RX shift register on the system clock edge that generates the sample SCK edge.
- TX order:
  - MSB-first sends bit TX_W-1 downward.
  - LSB-first sends bit 0 upward.
  - Bits beyond TX_W are 1.
- RX shift register:
  - MSB-first: shift left, MISO into bit 0.
  - LSB-first: shift right, MISO into bit RX_W-1.
  - len>RX_W: only the last RX_W bits are retained.
- TRAIL: SCK at cpol, SS still asserted, D cycles.
- On the last TRAIL cycle:
  - SS deasserts, MOSI=1.
  - received_data_o ← RX register.
  - done=1 for one cycle, busy=0, return to IDLE.
- received_data_o changes only at done.
- spi_abort_i=1 in any non-IDLE state:
  - Next cycle: IDLE, SS high, SCK=cpol, MOSI=1, busy=0.
  - No done pulse; received_data_o unchanged.
  - Abort in IDLE has no effect; abort and start in the same IDLE cycle → start honoured.
- spi_start_i while busy: ignored; no queuing.
- Input changes during a frame have no effect (all inputs latched), except spi_abort_i.

## Timing
- Start sampled high at cycle 0 → busy, SS and first MOSI valid at cycle 1.
- First SCK edge at cycle 1+D.
- done high at cycle 1+D·(2·len+2). Example: D=1, len=8 → cycle 19.
- Back-to-back: start may be sampled in the cycle after done; minimum inter-frame SS-high time is 1 cycle.
- SCK duty exactly 50%, period 2·D system clocks.
- Asynchronous reset mid-frame:
  - Outputs go to reset values immediately; no done.
  - First frame after release follows normal timing.

## Test plan
- Mode 0, MSB-first, D=1, len=8, TX top byte 8'hA5, MOSI looped to MISO.
  - Required: MOSI sequence 1,0,1,0,0,1,0,1; received_data_o[7:0]=8'hA5, upper bits 1s.
  - Required: done at cycle 19, exactly 8 rising SCK edges.
- Mode 3 (CPOL=1, CPHA=1), LSB-first, D=4, len=16, TX=48'h1234, MISO driven by bench as 16'hBEEF LSB-first.
  - Required: SCK idles high; received_data_o[RX_W-1:RX_W-16]=16'hBEEF; SCK period 8 cycles.
- len=100 > TX_W, MSB-first, TX=all 0s.
  - Required: MOSI 0 for 48 bits, then 1 for 52 bits; RX keeps the last 80 bits.
- NUM_CS=4, cs_mask=4'b0100.
  - Required: only SS[2] low during the frame; others stay high.
- Abort asserted at 5th SCK edge.
  - Required: next cycle SS high, busy=0, no done, received_data_o unchanged.
  - Required: a following start runs a normal frame.
- Reset pulse mid-XFER, plus start while busy.
  - Required: reset returns all outputs to reset values asynchronously.
  - Required: start pulses during busy produce no extra frame.

Source files
------------

// File: rtl/spi_master_gen2.sv
// SPI master: programmable frame length, SCK divider, CPOL/CPHA, bit order and
// multiple active-low selects, with busy/done handshake and abort.
module spi_master_gen2 #(
  parameter int TX_W   = 48,
  parameter int RX_W   = 80,
  parameter int NUM_CS = 1,
  parameter int DIV_W  = 8
) (
  input  logic              spi_clk_i,
  input  logic              spi_rst_i,
  input  logic              spi_start_i,
  input  logic              spi_abort_i,
  input  logic              spi_fbo_i,
  input  logic              spi_cpol_i,
  input  logic              spi_cpha_i,
  input  logic [DIV_W-1:0]  clock_divider_i,
  input  logic [7:0]        frame_len_i,
  input  logic [NUM_CS-1:0] cs_mask_i,
  input  logic [TX_W-1:0]   transmission_data_i,
  input  logic              MISO,
  output logic              SCK,
  output logic              MOSI,
  output logic [NUM_CS-1:0] SS,
  output logic              busy,
  output logic              done,
  output logic [RX_W-1:0]   received_data_o
);

  typedef enum logic [1:0] {IDLE, LEAD, XFER, TRAIL} state_t;

  state_t            state_q, state_d;
  logic [DIV_W-1:0]  div_cnt_q, div_cnt_d;
  logic [8:0]        edge_cnt_q, edge_cnt_d;
  logic              sck_q, sck_d, mosi_q, mosi_d, busy_q, busy_d, done_q, done_d;
  logic [NUM_CS-1:0] ss_q, ss_d;
  logic [RX_W-1:0]   rxo_q, rxo_d;

  logic [TX_W-1:0]   tx_sh_q, tx_sh_d;
  logic [RX_W-1:0]   rx_sh_q, rx_sh_d;
  logic              fbo_q, fbo_d, cpol_q, cpol_d, cpha_q, cpha_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [7:0]        len_q, len_d;

  logic              tick, sck_edge;
  logic [8:0]        edge_j, last_edge;
  logic [TX_W-1:0]   tx_next;

  function automatic logic tx_head(input logic [TX_W-1:0] sh, input logic msb_first);
    return msb_first ? sh[TX_W-1] : sh[0];
  endfunction

  // Vacated positions fill with 1 so bits beyond TX_W go out as 1.
  function automatic logic [TX_W-1:0] tx_shift(input logic [TX_W-1:0] sh, input logic msb_first);
    logic [TX_W:0] ext;
    if (msb_first) ext = {sh, 1'b1};
    else           ext = {1'b1, sh} >> 1;
    return ext[TX_W-1:0];
  endfunction

  function automatic logic [RX_W-1:0] rx_shift(input logic [RX_W-1:0] sh, input logic msb_first,
                                               input logic bit_in);
    logic [RX_W:0] ext;
    if (msb_first) ext = {sh, bit_in};
    else           ext = {bit_in, sh} >> 1;
    return ext[RX_W-1:0];
  endfunction

  assign tick      = (div_cnt_q == div_q);
  assign last_edge = {len_q, 1'b0};
  assign edge_j    = (state_q == LEAD) ? 9'd1 : edge_cnt_q + 9'd1;
  assign sck_edge  = tick && ((state_q == LEAD) || (state_q == XFER && edge_cnt_q != last_edge));
  assign tx_next   = tx_shift(tx_sh_q, fbo_q);

  always_comb begin
    state_d    = state_q;
    div_cnt_d  = div_cnt_q;
    edge_cnt_d = edge_cnt_q;
    sck_d      = sck_q;
    mosi_d     = mosi_q;
    ss_d       = ss_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    rxo_d      = rxo_q;
    tx_sh_d    = tx_sh_q;
    rx_sh_d    = rx_sh_q;
    fbo_d      = fbo_q;
    cpol_d     = cpol_q;
    cpha_d     = cpha_q;
    div_d      = div_q;
    len_d      = len_q;
    case (state_q)
      IDLE: begin
        sck_d  = spi_cpol_i;
        mosi_d = 1'b1;
        ss_d   = '1;
        busy_d = 1'b0;
        if (spi_start_i && frame_len_i != 8'd0) begin
          state_d    = LEAD;
          busy_d     = 1'b1;
          ss_d       = ~cs_mask_i;
          div_cnt_d  = '0;
          edge_cnt_d = '0;
          fbo_d      = spi_fbo_i;
          cpol_d     = spi_cpol_i;
          cpha_d     = spi_cpha_i;
          div_d      = clock_divider_i;
          len_d      = frame_len_i;
          tx_sh_d    = transmission_data_i;
          rx_sh_d    = '1;
          // With CPHA=1 the first bit is launched by SCK edge 1, not during LEAD.
          mosi_d     = spi_cpha_i ? 1'b1 : tx_head(transmission_data_i, spi_fbo_i);
        end
      end
      LEAD, XFER: begin
        div_cnt_d = tick ? '0 : div_cnt_q + 1'b1;
        if (tick) state_d = (state_q == XFER && edge_cnt_q == last_edge) ? TRAIL : XFER;
      end
      TRAIL: begin
        div_cnt_d = tick ? '0 : div_cnt_q + 1'b1;
        if (tick) begin
          state_d = IDLE;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          ss_d    = '1;
          mosi_d  = 1'b1;
          sck_d   = cpol_q;
          rxo_d   = rx_sh_q;
        end
      end
      default: state_d = IDLE;
    endcase

    // Odd edges sample when CPHA=0, even edges sample when CPHA=1; the others launch.
    if (sck_edge) begin
      sck_d      = ~sck_q;
      edge_cnt_d = edge_j;
      if (edge_j[0] ^ cpha_q) begin
        rx_sh_d = rx_shift(rx_sh_q, fbo_q, MISO);
      end else if (edge_j != last_edge) begin
        if (edge_j == 9'd1) begin
          mosi_d = tx_head(tx_sh_q, fbo_q);
        end else begin
          tx_sh_d = tx_next;
          mosi_d  = tx_head(tx_next, fbo_q);
        end
      end
    end

    if (state_q != IDLE && spi_abort_i) begin
      state_d   = IDLE;
      div_cnt_d = '0;
      ss_d      = '1;
      sck_d     = cpol_q;
      mosi_d    = 1'b1;
      busy_d    = 1'b0;
      done_d    = 1'b0;
      rxo_d     = rxo_q;
    end
  end

  always_ff @(posedge spi_clk_i or negedge spi_rst_i) begin
    if (!spi_rst_i) begin
      state_q    <= IDLE;
      div_cnt_q  <= '0;
      edge_cnt_q <= '0;
      sck_q      <= 1'b0;
      mosi_q     <= 1'b1;
      ss_q       <= '1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      rxo_q      <= '1;
    end else begin
      state_q    <= state_d;
      div_cnt_q  <= div_cnt_d;
      edge_cnt_q <= edge_cnt_d;
      sck_q      <= sck_d;
      mosi_q     <= mosi_d;
      ss_q       <= ss_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      rxo_q      <= rxo_d;
    end
  end

  always_ff @(posedge spi_clk_i) begin
    tx_sh_q <= tx_sh_d;
    rx_sh_q <= rx_sh_d;
    fbo_q   <= fbo_d;
    cpol_q  <= cpol_d;
    cpha_q  <= cpha_d;
    div_q   <= div_d;
    len_q   <= len_d;
  end

  assign SCK             = sck_q;
  assign MOSI            = mosi_q;
  assign SS              = ss_q;
  assign busy            = busy_q;
  assign done            = done_q;
  assign received_data_o = rxo_q;

endmodule

// File: tb/tb_spi_master_gen2.sv
// Bench for spi_master_gen2: randomized frames checked against a bit-level
// reference model of the serial protocol.
module tb_spi_master_gen2;
  localparam int TX_W = 48, RX_W = 80, NUM_CS = 4, DIV_W = 8;

  logic              clk = 1'b0, rst_n = 1'b0;
  logic              spi_start_i, spi_abort_i, spi_fbo_i, spi_cpol_i, spi_cpha_i;
  logic [DIV_W-1:0]  clock_divider_i;
  logic [7:0]        frame_len_i;
  logic [NUM_CS-1:0] cs_mask_i;
  logic [TX_W-1:0]   transmission_data_i;
  logic              MISO, SCK, MOSI, busy, done;
  logic [NUM_CS-1:0] SS;
  logic [RX_W-1:0]   received_data_o;
  logic              loopback = 1'b0, miso_drv = 1'b1;

  int n_vec = 0, n_err = 0;
  bit miso_bits [256];
  bit mosi_seen [256];
  int n_edges, n_rise, n_samp, done_cyc, done_cnt, first_edge_cyc, half_bad, ss_bad;
  logic busy_at1, sck_idle;
  bit spam = 1'b0;
  logic [RX_W-1:0] model_rx;

  always #5 clk = ~clk;
  assign MISO = loopback ? MOSI : miso_drv;

  spi_master_gen2 #(.TX_W(TX_W), .RX_W(RX_W), .NUM_CS(NUM_CS), .DIV_W(DIV_W)) dut (
    .spi_clk_i(clk), .spi_rst_i(rst_n), .spi_start_i(spi_start_i), .spi_abort_i(spi_abort_i),
    .spi_fbo_i(spi_fbo_i), .spi_cpol_i(spi_cpol_i), .spi_cpha_i(spi_cpha_i),
    .clock_divider_i(clock_divider_i), .frame_len_i(frame_len_i), .cs_mask_i(cs_mask_i),
    .transmission_data_i(transmission_data_i), .MISO(MISO), .SCK(SCK), .MOSI(MOSI), .SS(SS),
    .busy(busy), .done(done), .received_data_o(received_data_o));

  // Bit k of the frame as it should appear on MOSI.
  function automatic bit exp_tx_bit(input logic [TX_W-1:0] tx, input bit fbo, input int k);
    if (k >= TX_W) return 1'b1;
    return fbo ? tx[TX_W-1-k] : tx[k];
  endfunction

  // The last min(len,RX_W) received bits land at the register end dictated by bit order.
  function automatic logic [RX_W-1:0] exp_rx(input bit fbo, input int len);
    logic [RX_W-1:0] r;
    r = '1;
    for (int i = 0; i < RX_W && i < len; i++) begin
      if (fbo) r[i] = miso_bits[len-1-i];
      else     r[RX_W-1-i] = miso_bits[len-1-i];
    end
    return r;
  endfunction

  function automatic int mosi_bad(input logic [TX_W-1:0] tx, input bit fbo, input int len);
    int bad;
    bad = 0;
    for (int k = 0; k < len; k++) if (mosi_seen[k] != exp_tx_bit(tx, fbo, k)) bad++;
    return bad;
  endfunction

  task automatic run_frame(input bit fbo, input bit cpol, input bit cpha, input int d, input int len,
                           input logic [NUM_CS-1:0] mask, input logic [TX_W-1:0] tx,
                           input bit loop, input int stop_edges);
    int max_cyc, last_edge_cyc;
    logic prev_sck;
    bit leading;
    max_cyc = d * (2 * len + 2) + 20;
    spi_fbo_i = fbo; spi_cpol_i = cpol; spi_cpha_i = cpha;
    clock_divider_i = DIV_W'(d - 1); frame_len_i = 8'(len);
    cs_mask_i = mask; transmission_data_i = tx; loopback = loop;
    n_edges = 0; n_rise = 0; n_samp = 0; done_cyc = 0; done_cnt = 0;
    first_edge_cyc = 0; half_bad = 0; ss_bad = 0; busy_at1 = 1'b0; last_edge_cyc = 0;
    miso_drv = miso_bits[0];
    repeat (2) @(negedge clk);
    sck_idle = SCK; prev_sck = SCK;
    spi_start_i = 1'b1;
    @(negedge clk);
    spi_start_i = 1'b0;
    for (int cyc = 1; cyc <= max_cyc; cyc++) begin
      if (SCK !== prev_sck) begin
        n_edges++;
        if (n_edges == 1) first_edge_cyc = cyc;
        else if (cyc - last_edge_cyc != d) half_bad++;
        last_edge_cyc = cyc;
        if (SCK === 1'b1) n_rise++;
        leading = (prev_sck === cpol);
        if ((leading ^ cpha) && n_samp < 256) begin
          mosi_seen[n_samp] = MOSI;
          n_samp++;
          if (n_samp < 256) miso_drv = miso_bits[n_samp];
        end
        prev_sck = SCK;
      end
      if (cyc == 1) busy_at1 = busy;
      if (busy === 1'b1 && SS !== ~mask) ss_bad++;
      if (done === 1'b1) begin
        done_cnt++;
        if (done_cyc == 0) done_cyc = cyc;
      end
      if (spam) begin
        if (busy === 1'b1) begin
          spi_start_i = (cyc % 3 == 0);
          transmission_data_i = {$urandom, 16'($urandom)};
          frame_len_i = 8'($urandom); spi_fbo_i = ~fbo; spi_cpol_i = ~cpol; spi_cpha_i = ~cpha;
          clock_divider_i = DIV_W'($urandom_range(0, 7)); cs_mask_i = ~mask;
        end else begin
          spi_start_i = 1'b0; transmission_data_i = tx; frame_len_i = 8'(len);
          spi_fbo_i = fbo; spi_cpol_i = cpol; spi_cpha_i = cpha;
          clock_divider_i = DIV_W'(d - 1); cs_mask_i = mask;
        end
      end
      if (stop_edges != 0 && n_edges == stop_edges) break;
      if (done_cyc != 0 && cyc > done_cyc) break;
      @(negedge clk);
    end
    spi_start_i = 1'b0;
  endtask

  task automatic test_reset;
    @(negedge clk);
    n_vec++; if (SCK !== 1'b0) begin n_err++; $display("FAIL reset_sck got %b want 0", SCK); end
    n_vec++; if (MOSI !== 1'b1) begin n_err++; $display("FAIL reset_mosi got %b want 1", MOSI); end
    n_vec++; if (SS !== 4'hF) begin n_err++; $display("FAIL reset_ss got %h want F", SS); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", busy); end
    n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done got %b want 0", done); end
    n_vec++; if (received_data_o !== {RX_W{1'b1}}) begin n_err++; $display("FAIL reset_rx got %h want all ones", received_data_o); end
    rst_n = 1'b1; spi_cpol_i = 1'b1;
    repeat (2) @(negedge clk);
    n_vec++; if (SCK !== 1'b1) begin n_err++; $display("FAIL idle_sck_cpol1 got %b want 1", SCK); end
    spi_cpol_i = 1'b0; frame_len_i = 8'd0; spi_start_i = 1'b1;
    @(negedge clk);
    spi_start_i = 1'b0;
    @(negedge clk);
    n_vec++; if (SCK !== 1'b0) begin n_err++; $display("FAIL idle_sck_cpol0 got %b want 0", SCK); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL len0_start_busy got %b want 0", busy); end
    model_rx = '1;
  endtask

  task automatic test_mode0_loop;
    logic [TX_W-1:0] tx;
    logic [RX_W-1:0] exp;
    tx = {8'hA5, 8'($urandom), $urandom};
    for (int k = 0; k < 8; k++) miso_bits[k] = exp_tx_bit(tx, 1'b1, k);
    run_frame(1'b1, 1'b0, 1'b0, 1, 8, 4'b0001, tx, 1'b1, 0);
    exp = exp_rx(1'b1, 8);
    n_vec++; if (n_samp != 8) begin n_err++; $display("FAIL m0_samples got %0d want 8", n_samp); end
    n_vec++; if (mosi_bad(tx, 1'b1, 8) != 0) begin n_err++; $display("FAIL m0_mosi_seq bad bits %0d want 0", mosi_bad(tx, 1'b1, 8)); end
    n_vec++; if (received_data_o[7:0] !== 8'hA5) begin n_err++; $display("FAIL m0_rx_byte got %h want a5", received_data_o[7:0]); end
    n_vec++; if (received_data_o !== exp) begin n_err++; $display("FAIL m0_rx got %h want %h", received_data_o, exp); end
    n_vec++; if (done_cyc != 19) begin n_err++; $display("FAIL m0_done_cycle got %0d want 19", done_cyc); end
    n_vec++; if (n_rise != 8) begin n_err++; $display("FAIL m0_rising got %0d want 8", n_rise); end
    n_vec++; if (first_edge_cyc != 2) begin n_err++; $display("FAIL m0_first_edge got %0d want 2", first_edge_cyc); end
    n_vec++; if (busy_at1 !== 1'b1) begin n_err++; $display("FAIL m0_busy_cyc1 got %b want 1", busy_at1); end
    n_vec++; if (done_cnt != 1) begin n_err++; $display("FAIL m0_done_pulses got %0d want 1", done_cnt); end
    n_vec++; if (ss_bad != 0) begin n_err++; $display("FAIL m0_ss bad cycles %0d want 0", ss_bad); end
    model_rx = exp;
  endtask

  task automatic test_mode3;
    logic [15:0] pat;
    logic [RX_W-1:0] exp;
    pat = 16'hBEEF;
    for (int k = 0; k < 16; k++) miso_bits[k] = pat[k];
    run_frame(1'b0, 1'b1, 1'b1, 4, 16, 4'b0001, 48'h1234, 1'b0, 0);
    exp = exp_rx(1'b0, 16);
    n_vec++; if (sck_idle !== 1'b1) begin n_err++; $display("FAIL m3_sck_idle got %b want 1", sck_idle); end
    n_vec++; if (received_data_o[RX_W-1 -: 16] !== 16'hBEEF) begin n_err++; $display("FAIL m3_rx_top got %h want beef", received_data_o[RX_W-1 -: 16]); end
    n_vec++; if (received_data_o !== exp) begin n_err++; $display("FAIL m3_rx got %h want %h", received_data_o, exp); end
    n_vec++; if (mosi_bad(48'h1234, 1'b0, 16) != 0) begin n_err++; $display("FAIL m3_mosi bad bits %0d want 0", mosi_bad(48'h1234, 1'b0, 16)); end
    n_vec++; if (half_bad != 0) begin n_err++; $display("FAIL m3_half_period bad %0d want 0", half_bad); end
    n_vec++; if (done_cyc != 1 + 4 * 34) begin n_err++; $display("FAIL m3_done_cycle got %0d want %0d", done_cyc, 1 + 4 * 34); end
    n_vec++; if (SCK !== 1'b1) begin n_err++; $display("FAIL m3_sck_end got %b want 1", SCK); end
    model_rx = exp;
  endtask

  task automatic test_long;
    int d;
    bit cpol, cpha;
    logic [RX_W-1:0] exp;
    d = $urandom_range(1, 3); cpol = 1'($urandom); cpha = 1'($urandom);
    for (int k = 0; k < 100; k++) miso_bits[k] = 1'($urandom);
    run_frame(1'b1, cpol, cpha, d, 100, 4'b0010, '0, 1'b0, 0);
    exp = exp_rx(1'b1, 100);
    n_vec++; if (n_samp != 100) begin n_err++; $display("FAIL long_samples got %0d want 100", n_samp); end
    n_vec++; if (mosi_bad('0, 1'b1, 100) != 0) begin n_err++; $display("FAIL long_mosi bad bits %0d want 0", mosi_bad('0, 1'b1, 100)); end
    n_vec++; if (received_data_o !== exp) begin n_err++; $display("FAIL long_rx got %h want %h", received_data_o, exp); end
    n_vec++; if (done_cyc != 1 + d * 202) begin n_err++; $display("FAIL long_done_cycle got %0d want %0d", done_cyc, 1 + d * 202); end
    model_rx = exp;
  endtask

  task automatic test_cs;
    logic [RX_W-1:0] exp;
    bit cpol, cpha, fbo;
    cpol = 1'($urandom); cpha = 1'($urandom); fbo = 1'($urandom);
    for (int k = 0; k < 12; k++) miso_bits[k] = 1'($urandom);
    run_frame(fbo, cpol, cpha, 2, 12, 4'b0100, {$urandom, 16'($urandom)}, 1'b0, 0);
    exp = exp_rx(fbo, 12);
    n_vec++; if (busy_at1 !== 1'b1) begin n_err++; $display("FAIL cs_busy got %b want 1", busy_at1); end
    n_vec++; if (ss_bad != 0) begin n_err++; $display("FAIL cs_ss_during bad cycles %0d want 0", ss_bad); end
    n_vec++; if (SS !== 4'hF) begin n_err++; $display("FAIL cs_ss_after got %h want f", SS); end
    n_vec++; if (received_data_o !== exp) begin n_err++; $display("FAIL cs_rx got %h want %h", received_data_o, exp); end
    model_rx = exp;
  endtask

  task automatic test_random;
    bit fbo, cpol, cpha, loop;
    int d, len;
    logic [NUM_CS-1:0] mask;
    logic [TX_W-1:0] tx;
    logic [RX_W-1:0] exp;
    for (int f = 0; f < 6; f++) begin
      fbo = 1'($urandom); cpol = 1'($urandom); cpha = 1'($urandom); loop = 1'($urandom);
      d = $urandom_range(1, 4); len = $urandom_range(1, 40);
      mask = NUM_CS'($urandom_range(1, 15)); tx = {$urandom, 16'($urandom)};
      for (int k = 0; k < len; k++) miso_bits[k] = loop ? exp_tx_bit(tx, fbo, k) : 1'($urandom);
      run_frame(fbo, cpol, cpha, d, len, mask, tx, loop, 0);
      exp = exp_rx(fbo, len);
      n_vec++; if (received_data_o !== exp) begin n_err++; $display("FAIL rnd%0d_rx got %h want %h", f, received_data_o, exp); end
      n_vec++; if (mosi_bad(tx, fbo, len) != 0 || n_samp != len) begin n_err++; $display("FAIL rnd%0d_mosi bad %0d samples %0d want 0/%0d", f, mosi_bad(tx, fbo, len), n_samp, len); end
      n_vec++; if (done_cyc != 1 + d * (2 * len + 2)) begin n_err++; $display("FAIL rnd%0d_done_cycle got %0d want %0d", f, done_cyc, 1 + d * (2 * len + 2)); end
      n_vec++; if (half_bad != 0 || n_edges != 2 * len) begin n_err++; $display("FAIL rnd%0d_sck bad %0d edges %0d want 0/%0d", f, half_bad, n_edges, 2 * len); end
      model_rx = exp;
    end
  endtask

  task automatic test_abort;
    bit cpol;
    int stray;
    logic [RX_W-1:0] exp;
    cpol = 1'($urandom);
    for (int k = 0; k < 10; k++) miso_bits[k] = 1'($urandom);
    run_frame(1'b1, cpol, 1'($urandom), 2, 10, 4'b0001, {$urandom, 16'($urandom)}, 1'b0, 5);
    spi_abort_i = 1'b1;
    @(negedge clk);
    spi_abort_i = 1'b0;
    n_vec++; if (SS !== 4'hF) begin n_err++; $display("FAIL abort_ss got %h want f", SS); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL abort_busy got %b want 0", busy); end
    n_vec++; if (MOSI !== 1'b1 || SCK !== cpol) begin n_err++; $display("FAIL abort_lines mosi %b sck %b want 1 %b", MOSI, SCK, cpol); end
    n_vec++; if (received_data_o !== model_rx) begin n_err++; $display("FAIL abort_rx got %h want %h", received_data_o, model_rx); end
    stray = 0;
    for (int c = 0; c < 60; c++) begin
      if (done !== 1'b0 || busy !== 1'b0) stray++;
      @(negedge clk);
    end
    n_vec++; if (stray != 0) begin n_err++; $display("FAIL abort_no_done stray cycles %0d want 0", stray); end
    for (int k = 0; k < 9; k++) miso_bits[k] = 1'($urandom);
    run_frame(1'b0, 1'b0, 1'b1, 1, 9, 4'b1000, {$urandom, 16'($urandom)}, 1'b0, 0);
    exp = exp_rx(1'b0, 9);
    n_vec++; if (received_data_o !== exp || done_cyc != 21) begin n_err++; $display("FAIL abort_next_frame rx %h done %0d want %h 21", received_data_o, done_cyc, exp); end
    model_rx = exp;
  endtask

  task automatic test_reset_mid;
    int stray;
    logic [RX_W-1:0] exp;
    for (int k = 0; k < 12; k++) miso_bits[k] = 1'($urandom);
    run_frame(1'b1, 1'b1, 1'b0, 3, 12, 4'b0011, {$urandom, 16'($urandom)}, 1'b0, 3);
    #2 rst_n = 1'b0;
    #1;
    n_vec++; if (SCK !== 1'b0 || MOSI !== 1'b1) begin n_err++; $display("FAIL rstmid_lines sck %b mosi %b want 0 1", SCK, MOSI); end
    n_vec++; if (SS !== 4'hF || busy !== 1'b0 || done !== 1'b0) begin n_err++; $display("FAIL rstmid_ctrl ss %h busy %b done %b want f 0 0", SS, busy, done); end
    n_vec++; if (received_data_o !== {RX_W{1'b1}}) begin n_err++; $display("FAIL rstmid_rx got %h want all ones", received_data_o); end
    model_rx = '1;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    stray = 0;
    for (int c = 0; c < 100; c++) begin
      if (done !== 1'b0 || busy !== 1'b0) stray++;
      @(negedge clk);
    end
    n_vec++; if (stray != 0) begin n_err++; $display("FAIL rstmid_no_done stray cycles %0d want 0", stray); end
    for (int k = 0; k < 7; k++) miso_bits[k] = 1'($urandom);
    run_frame(1'b1, 1'b0, 1'b0, 2, 7, 4'b0001, {$urandom, 16'($urandom)}, 1'b0, 0);
    exp = exp_rx(1'b1, 7);
    n_vec++; if (received_data_o !== exp || done_cyc != 1 + 2 * 16) begin n_err++; $display("FAIL rstmid_next_frame rx %h done %0d want %h %0d", received_data_o, done_cyc, exp, 1 + 2 * 16); end
    model_rx = exp;
  endtask

  task automatic test_start_busy;
    int stray;
    logic [TX_W-1:0] tx;
    logic [RX_W-1:0] exp;
    tx = {$urandom, 16'($urandom)};
    for (int k = 0; k < 10; k++) miso_bits[k] = 1'($urandom);
    spam = 1'b1;
    run_frame(1'b0, 1'b1, 1'b0, 2, 10, 4'b0101, tx, 1'b0, 0);
    spam = 1'b0;
    exp = exp_rx(1'b0, 10);
    n_vec++; if (done_cnt != 1) begin n_err++; $display("FAIL busy_done_pulses got %0d want 1", done_cnt); end
    n_vec++; if (received_data_o !== exp) begin n_err++; $display("FAIL busy_rx_latched got %h want %h", received_data_o, exp); end
    n_vec++; if (mosi_bad(tx, 1'b0, 10) != 0 || ss_bad != 0) begin n_err++; $display("FAIL busy_latched_io mosi bad %0d ss bad %0d want 0 0", mosi_bad(tx, 1'b0, 10), ss_bad); end
    n_vec++; if (done_cyc != 1 + 2 * 22) begin n_err++; $display("FAIL busy_done_cycle got %0d want %0d", done_cyc, 1 + 2 * 22); end
    stray = 0;
    for (int c = 0; c < 40; c++) begin
      if (busy !== 1'b0 || done !== 1'b0) stray++;
      @(negedge clk);
    end
    n_vec++; if (stray != 0) begin n_err++; $display("FAIL busy_no_extra_frame stray cycles %0d want 0", stray); end
  endtask

  initial begin
    spi_start_i = 1'b0; spi_abort_i = 1'b0; spi_fbo_i = 1'b1; spi_cpol_i = 1'b0; spi_cpha_i = 1'b0;
    clock_divider_i = '0; frame_len_i = 8'd8; cs_mask_i = 4'b0001; transmission_data_i = '0;
    model_rx = '1;
    test_reset;
    test_mode0_loop;
    test_mode3;
    test_long;
    test_cs;
    test_random;
    test_abort;
    test_reset_mid;
    test_start_busy;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not complete, vectors %0d", n_vec);
    $fatal(1, "watchdog");
  end

endmodule
